// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar blocks: FSM state type and index-width helper.
package xbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } xbar_state_e;

  function automatic int xbar_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/xbar_scatter_if.sv
// Ready/valid bundle for xbar_scatter: input vector side and output beat side.
interface xbar_scatter_if
  import xbar_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int NUM_ELEMS  = 32
);
  localparam int IDX_W = xbar_idx_w(NUM_ELEMS);

  logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] data_in;
  logic [NUM_ELEMS-1:0][IDX_W-1:0]      dst;
  logic [NUM_ELEMS-1:0]                 en;
  logic                                 data_in_val;
  logic                                 data_in_rdy;

  logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] data_out;
  logic [NUM_ELEMS-1:0]                 data_out_mask;
  logic                                 data_out_last;
  logic                                 data_out_val;
  logic                                 data_out_rdy;

  // Upstream/downstream environment view.
  modport master (
    output data_in, dst, en, data_in_val, data_out_rdy,
    input  data_in_rdy, data_out, data_out_mask, data_out_last, data_out_val
  );

  // Crossbar view.
  modport slave (
    input  data_in, dst, en, data_in_val, data_out_rdy,
    output data_in_rdy, data_out, data_out_mask, data_out_last, data_out_val
  );

endinterface

// File: rtl/xbar_scatter_arb.sv
// Fixed-priority arbiter for one output lane: lowest requesting input index wins.
module xbar_scatter_arb #(
  parameter int N = 32
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));
  assign any = |req;

endmodule

// File: rtl/xbar_scatter.sv
// Scatter crossbar: steers each enabled input to lane dst[i], serialising lane conflicts.
// Optional conflict counter enabled by defining XBAR_SCATTER_CONFLICT_CNT_EN.
module xbar_scatter
  import xbar_pkg::*;
#(
  parameter int ELEM_WIDTH = 32,
  parameter int NUM_ELEMS  = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  xbar_scatter_if.slave        bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam int IDX_W = xbar_idx_w(NUM_ELEMS);

  typedef logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] vec_t;
  typedef logic [NUM_ELEMS-1:0][IDX_W-1:0]      idx_vec_t;

  xbar_state_e          state, next_state;
  logic [NUM_ELEMS-1:0] pending;
  vec_t                 cap_data;
  idx_vec_t             cap_dst;

  vec_t                 src_data;
  idx_vec_t             src_dst;
  logic [NUM_ELEMS-1:0] src_valid;

  logic [NUM_ELEMS-1:0][NUM_ELEMS-1:0] req_mat;
  logic [NUM_ELEMS-1:0][NUM_ELEMS-1:0] gnt_mat;
  logic [NUM_ELEMS-1:0]                gnt_all;
  logic [NUM_ELEMS-1:0]                beat_mask;
  logic [NUM_ELEMS-1:0]                remaining;
  vec_t                                beat_data;
  logic                                beat_last;

  logic advance, accept, load;

  // Beat 0 is formed straight from the input port; later beats from the captured copy.
  always_comb begin
    src_valid = bus.en;
    src_data  = bus.data_in;
    src_dst   = bus.dst;
    if (state == BUSY) begin
      src_valid = pending;
      src_data  = cap_data;
      src_dst   = cap_dst;
    end
  end

  always_comb begin
    req_mat = '0;
    for (int j = 0; j < NUM_ELEMS; j++) begin
      for (int i = 0; i < NUM_ELEMS; i++) begin
        req_mat[j][i] = src_valid[i] && (src_dst[i] == IDX_W'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_ELEMS; j++) begin : g_lane
    xbar_scatter_arb #(.N(NUM_ELEMS)) u_arb (
      .req (req_mat[j]),
      .gnt (gnt_mat[j]),
      .any (beat_mask[j])
    );
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    beat_data = '0;
    gnt_all   = '0;
    for (int j = 0; j < NUM_ELEMS; j++) begin
      gnt_all = gnt_all | gnt_mat[j];
      for (int i = 0; i < NUM_ELEMS; i++) begin
        if (gnt_mat[j][i]) beat_data[j] = src_data[i];
      end
    end
    remaining = src_valid & ~gnt_all;
    beat_last = (remaining == '0);
  end

  assign advance         = !bus.data_out_val || bus.data_out_rdy;
  assign bus.data_in_rdy = (state == IDLE) && advance;
  assign accept          = bus.data_in_val && bus.data_in_rdy;
  assign load            = accept || ((state == BUSY) && advance);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && !beat_last) next_state = BUSY;
      BUSY:    if (advance && beat_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.data_out      <= '0;
      bus.data_out_mask <= '0;
      bus.data_out_last <= 1'b0;
      bus.data_out_val  <= 1'b0;
      pending           <= '0;
    end else if (load) begin
      bus.data_out      <= beat_data;
      bus.data_out_mask <= beat_mask;
      bus.data_out_last <= beat_last;
      bus.data_out_val  <= 1'b1;
      pending           <= remaining;
    end else if (bus.data_out_rdy) begin
      bus.data_out_val  <= 1'b0;
    end
  end

  // NOTE: capture registers carry no reset; pending is reset and qualifies their contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_data <= bus.data_in;
      cap_dst  <= bus.dst;
    end
  end

`ifdef XBAR_SCATTER_CONFLICT_CNT_EN
  // Every BUSY load is a non-first beat; count saturates instead of wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      conflict_cnt <= '0;
    end else if ((state == BUSY) && advance && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_scatter.sv
// Self-checking bench for xbar_scatter: directed scenarios plus randomized vectors
// compared every cycle against a per-lane queue model of the scatter rules.
module tb_xbar_scatter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 3;

`ifdef XBAR_SCATTER_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef logic [N-1:0][1:0]   dst_t;

  typedef struct {
    vec_t         data;
    logic [N-1:0] mask;
    logic         last;
  } beat_t;

  localparam logic [W-1:0] A = 16'hA1A1;
  localparam logic [W-1:0] B = 16'hB2B2;
  localparam logic [W-1:0] C = 16'hC3C3;
  localparam logic [W-1:0] D = 16'hD4D4;

  logic          clk;
  logic          arst_n;
  logic [CW-1:0] cnt;
  bit            rand_rdy;

  int            compared;
  int            mismatched;
  beat_t         exp_q[$];
  logic [CW-1:0] exp_cnt;

  xbar_scatter_if #(.ELEM_WIDTH(W), .NUM_ELEMS(N)) bus ();

  xbar_scatter #(.ELEM_WIDTH(W), .NUM_ELEMS(N), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .bus          (bus),
    .conflict_cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Beat k carries, on each lane j, the k-th enabled input (ascending index) aimed at j.
  function automatic void model_push(input vec_t d, input dst_t ds, input logic [N-1:0] e);
    int    hits[N];
    int    nb;
    beat_t b;
    nb = 1;
    for (int j = 0; j < N; j++) begin
      hits[j] = 0;
      for (int i = 0; i < N; i++) if (e[i] && int'(ds[i]) == j) hits[j]++;
      if (hits[j] > nb) nb = hits[j];
    end
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.mask = '0;
      b.last = (k == nb - 1);
      for (int j = 0; j < N; j++) begin
        int seen;
        seen = 0;
        for (int i = 0; i < N; i++) begin
          if (e[i] && int'(ds[i]) == j) begin
            if (seen == k) begin
              b.data[j] = d[i];
              b.mask[j] = 1'b1;
            end
            seen++;
          end
        end
      end
      exp_q.push_back(b);
    end
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!arst_n) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      check("out_val", 64'(bus.data_out_val), 64'(exp_q.size() != 0));
      check("in_rdy", 64'(bus.data_in_rdy),
            64'((exp_q.size() == 0) || (exp_q.size() == 1 && bus.data_out_rdy)));
      if (exp_q.size() != 0) begin
        check("data_out", 64'(bus.data_out), 64'(exp_q[0].data));
        check("mask", 64'(bus.data_out_mask), 64'(exp_q[0].mask));
        check("last", 64'(bus.data_out_last), 64'(exp_q[0].last));
      end
      check("conflict_cnt", 64'(cnt), 64'(exp_cnt));
      if (bus.data_out_val && bus.data_out_rdy && exp_q.size() != 0) begin
        if (!exp_q[0].last && CNT_EN && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        void'(exp_q.pop_front());
      end
      if (bus.data_in_val && bus.data_in_rdy) model_push(bus.data_in, bus.dst, bus.en);
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.data_out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and hold it until accepted; returns just after the accepting edge.
  task automatic send(input vec_t d, input dst_t ds, input logic [N-1:0] e);
    bus.data_in     = d;
    bus.dst         = ds;
    bus.en          = e;
    bus.data_in_val = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.data_in_rdy) break;
      if (c == 299) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout at %0t: vector not accepted within 300 cycles", $time);
      end
    end
    @(posedge clk);
    #1;
    bus.data_in_val = 1'b0;
  endtask

  vec_t d_abcd;
  vec_t rv;
  dst_t rd;

  initial begin
    watchdog_guard();
  end

  task automatic watchdog_guard();
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  endtask

  initial begin
    compared         = 0;
    mismatched       = 0;
    exp_cnt          = '0;
    rand_rdy         = 1'b0;
    arst_n           = 1'b0;
    bus.data_in      = '0;
    bus.dst          = '0;
    bus.en           = '0;
    bus.data_in_val  = 1'b0;
    bus.data_out_rdy = 1'b1;
    d_abcd           = {D, C, B, A};
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_val", 64'(bus.data_out_val), 64'(0));
    check("rst_in_rdy", 64'(bus.data_in_rdy), 64'(1));
    check("rst_mask", 64'(bus.data_out_mask), 64'(0));
    check("rst_data", 64'(bus.data_out), 64'(0));
    check("rst_last", 64'(bus.data_out_last), 64'(0));
    check("rst_cnt", 64'(cnt), 64'(0));

    // Identity mapping: one full beat.
    send(d_abcd, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF);
    check("id_data", 64'(bus.data_out), 64'({D, C, B, A}));
    check("id_mask", 64'(bus.data_out_mask), 64'(4'hF));
    check("id_last", 64'(bus.data_out_last), 64'(1));
    check("id_cnt", 64'(cnt), 64'(0));

    // All inputs to lane 0: four beats, lowest index first.
    send(d_abcd, {2'd0, 2'd0, 2'd0, 2'd0}, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check("l0_data", 64'(bus.data_out[0]), 64'(d_abcd[k]));
      check("l0_mask", 64'(bus.data_out_mask), 64'(4'h1));
      check("l0_last", 64'(bus.data_out_last), 64'(k == 3));
      check("l0_in_rdy", 64'(bus.data_in_rdy), 64'(k == 3));
      if (k == 3) check("l0_cnt", 64'(cnt), CNT_EN ? 64'(3) : 64'(0));
      if (k < 3) tick();
    end

    // Partial enable: only inputs 0 and 2 survive.
    send(d_abcd, {2'd3, 2'd3, 2'd1, 2'd1}, 4'b0101);
    check("pe_data", 64'(bus.data_out), 64'({C, 16'h0, A, 16'h0}));
    check("pe_mask", 64'(bus.data_out_mask), 64'(4'b1010));
    check("pe_last", 64'(bus.data_out_last), 64'(1));

    // Empty vector still produces one beat; next vector accepted immediately.
    send(d_abcd, {2'd0, 2'd1, 2'd2, 2'd3}, 4'h0);
    check("em_val", 64'(bus.data_out_val), 64'(1));
    check("em_mask", 64'(bus.data_out_mask), 64'(0));
    check("em_last", 64'(bus.data_out_last), 64'(1));
    check("em_in_rdy", 64'(bus.data_in_rdy), 64'(1));
    send(d_abcd, {2'd3, 2'd2, 2'd1, 2'd0}, 4'hF);
    tick();

    // Backpressure on a two-beat vector.
    bus.data_out_rdy = 1'b0;
    send(d_abcd, {2'd2, 2'd1, 2'd0, 2'd0}, 4'hF);
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 64'(bus.data_out), 64'({16'h0, D, C, A}));
      check("bp_mask", 64'(bus.data_out_mask), 64'(4'b0111));
      check("bp_in_rdy", 64'(bus.data_in_rdy), 64'(0));
      tick();
    end
    bus.data_out_rdy = 1'b1;
    tick();
    check("bp_beat1", 64'(bus.data_out), 64'({16'h0, 16'h0, 16'h0, B}));
    check("bp_last", 64'(bus.data_out_last), 64'(1));
    tick();

    // Reset during beat 1 of a four-beat vector.
    send(d_abcd, {2'd0, 2'd0, 2'd0, 2'd0}, 4'hF);
    tick();
    #1 arst_n = 1'b0;
    #1;
    check("mr_val", 64'(bus.data_out_val), 64'(0));
    check("mr_mask", 64'(bus.data_out_mask), 64'(0));
    check("mr_data", 64'(bus.data_out), 64'(0));
    @(negedge clk);
    #2 arst_n = 1'b1;
    tick();
    check("mr_in_rdy", 64'(bus.data_in_rdy), 64'(1));
    check("mr_cnt", 64'(cnt), 64'(0));
    repeat (4) tick();

    // Randomized vectors with random output backpressure.
    rand_rdy = 1'b1;
    for (int v = 0; v < 300; v++) begin
      for (int i = 0; i < N; i++) begin
        rv[i] = W'($urandom);
        rd[i] = 2'($urandom_range(0, N - 1));
      end
      send(rv, rd, (v % 16 == 7) ? 4'h0 : 4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (c == 499) begin
        compared++;
        mismatched++;
        $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
      end
    end
    rand_rdy = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xbar_scatter.md
# xbar_scatter

Scatter crossbar: each input element i is steered to the output lane named by its destination index `dst[i]`. It is the write-side counterpart of the gather crossbar, where each output lane picks one input. When several enabled inputs target the same output lane, the block issues them over successive output beats, lowest input index first. It sits between the vector datapath and lane-addressed consumers (register-file write ports, scatter buffers), using the same ready/valid discipline.

## Interface
- `ELEM_WIDTH`, 32, data width of one element
- `NUM_ELEMS`, 32, number of input and output lanes; power of two, ≥2
- `CNT_WIDTH`, 32, width of the conflict counter
- `clk` in 1: clock
- `arst_n` in 1: reset, asynchronous, active-low. One clock domain; polarity and synchronicity are fixed.
- `data_in` in NUM_ELEMS×ELEM_WIDTH: input elements
- `dst` in NUM_ELEMS×$clog2(NUM_ELEMS): destination lane per input
- `en` in NUM_ELEMS: per-input enable; disabled inputs are dropped
- `data_in_val` in 1: input vector valid
- `data_in_rdy` out 1: input vector accepted when val&rdy
- `data_out` out NUM_ELEMS×ELEM_WIDTH: output elements, registered
- `data_out_mask` out NUM_ELEMS: lane j carries a valid element this beat
- `data_out_last` out 1: final beat of the current input vector
- `data_out_val` out 1: output beat valid
- `data_out_rdy` in 1: output beat consumed when val&rdy
- `conflict_cnt` out CNT_WIDTH: number of extra beats caused by conflicts

## Operation
- States:
  - IDLE: no pending elements.
  - BUSY: a `pending` bitmask plus captured `data_in`/`dst` registers hold elements not yet issued.
- Beat formation: for each output lane j, grant the lowest-index input i with `pending[i] && dst[i]==j`. Then `data_out[j]=data[i]` and `data_out_mask[j]=1`. Lanes with no grant get mask 0 and data 0.
- Granted inputs are cleared from `pending`. A beat is `last` when nothing remains pending after the grant.
- `advance = !data_out_val || data_out_rdy`.
- `data_in_rdy = (state==IDLE) && advance`.
- IDLE, on accept:
  - Form beat 0 from `data_in`/`en` directly and load the output register.
  - Capture `data_in`/`dst` and load `pending = en & ~grants0`.
  - Go to BUSY if `pending != 0`, otherwise stay in IDLE.
- BUSY, on advance: form the next beat from the captured registers and load it into the output register. Go to IDLE when that beat is last.
- With `en` all zero, one beat is issued with mask 0 and last=1. Vectors are never silently swallowed.
- Beat count per vector = max over j of the number of enabled inputs with `dst==j`, minimum 1.
- While `data_out_val && !data_out_rdy`, all output fields and `pending` hold stable.
- Disabled inputs never appear on any lane, regardless of their `dst`.

## Timing
- Latency: a vector accepted at edge T has beat 0 valid after edge T, with beat k valid after edge T+k given no backpressure.
- Conflict-free vectors stream at one per cycle. A vector needing B beats blocks input for B−1 extra cycles.
- `data_in_rdy` is combinational from state and `data_out_val`/`data_out_rdy`. It has no combinational path from `data_in_val`.
- Reset values: `data_out_val`=0, `data_out`=0, `data_out_mask`=0, `data_out_last`=0, `conflict_cnt`=0, state IDLE, `pending`=0. `data_in_rdy` therefore reads 1 after reset.
- Reset asserted mid-vector: pending elements are discarded, and the output goes invalid asynchronously.
- `conflict_cnt` increments once per issued non-first beat, i.e. when a BUSY beat loads. It saturates at all-ones and does not wrap.

## Configuration
- `XBAR_SCATTER_CONFLICT_CNT_EN`
- Defined: `conflict_cnt` counter logic is present and behaves as specified above.
- Undefined: no counter flop exists; `conflict_cnt` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `xbar_pkg`:
  - `xbar_state_e` (IDLE, BUSY)
  - function `xbar_idx_w(n)` returning $clog2(n)
- Sub-module `xbar_scatter_arb`: one per output lane.
  - Inputs: `req` (NUM_ELEMS) = `pending & (dst==j)`.
  - Outputs: one-hot `gnt` (lowest index wins) and `any`.
  - The parent ORs all `gnt` vectors to clear `pending`, and uses each `gnt` to select that lane's data.

## Test plan
- Identity, NUM_ELEMS=4: `dst`={0,1,2,3}, en=4'hF, data={A,B,C,D}, out_rdy=1 → one beat, data_out={A,B,C,D}, mask=F, last=1 at T+1; counter stays 0.
- All to lane 0, NUM_ELEMS=4: data={A,B,C,D}, en=F → 4 beats on lane 0: A, B, C, D, mask=4'h1 each, last only on the 4th beat; `data_in_rdy` low for 3 cycles; `conflict_cnt`=3.
- Partial enable: `dst`={1,1,3,3}, en=4'b0101 → one beat, lane1=A, lane3=C, mask=4'b1010, last=1.
- Empty vector: en=0 → one beat, mask=0, last=1; the next vector is accepted the following cycle.
- Backpressure: `data_out_rdy`=0 for 5 cycles during a 2-beat vector → beat 0 holds stable, `data_in_rdy`=0, no element is lost or duplicated after release.
- Reset mid-operation: assert `arst_n`=0 during beat 1 of 4 → `data_out_val`=0 immediately; after release `data_in_rdy`=1, `conflict_cnt`=0, and no stale beats are issued.
